// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bus writes fill a DEPTH-entry FIFO, and a frame FSM
// serialises each character on TxD (start, LSB-first data, optional parity, 1-2 stop bits).
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Enable,
    input  logic                     IOCS,
    input  logic                     IORW,
    input  logic [1:0]               IOADDR,
    input  logic [DATA_W-1:0]        DATA,
    input  logic [1:0]               parity_mode,
    input  logic                     two_stop,
    output logic                     TxD,
    output logic                     TBR,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    state_t            state;
    logic [TW-1:0]     tick;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              parity_on;
    logic              parity_bit;
    logic              two_stop_q;

    logic              push_req;
    logic              clr_req;
    logic              full;
    logic              empty;
    logic              bit_end;
    logic              stop_done;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] head;

    assign push_req  = IOCS && !IORW && (IOADDR == 2'b00);
    assign clr_req   = IOCS && !IORW && (IOADDR == 2'b01) && DATA[0];
    assign full      = (fifo_count == (AW+1)'(DEPTH));
    assign empty     = (fifo_count == '0);
    assign bit_end   = Enable && (tick == TW'(OVERSAMPLE - 1));
    assign stop_done = (state == ST_STOP) && bit_end && (bit_cnt == BW'(two_stop_q));

    // A new frame starts on an Enable tick from IDLE, or directly at the end of
    // the last stop bit so consecutive frames have no idle gap.
    assign pop  = !empty && (((state == ST_IDLE) && Enable) || stop_done);
    assign push = push_req && (!full || pop);
    assign head = mem[rd_ptr];

    assign TBR     = !full;
    assign tx_busy = (state != ST_IDLE) || !empty;

    // NOTE: the character storage carries no reset; only pointers and count
    // define which entries are valid, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= DATA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (clr_req) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: every register here uses <= so all branches see the pre-edge state,
    // e.g. TxD takes shift[1] because shift moves on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            tick       <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_on  <= 1'b0;
            parity_bit <= 1'b0;
            two_stop_q <= 1'b0;
            TxD        <= 1'b1;
        end else if (pop) begin
            state      <= ST_START;
            tick       <= '0;
            bit_cnt    <= '0;
            shift      <= head;
            parity_on  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            parity_bit <= (^head) ^ (parity_mode == 2'b10);
            two_stop_q <= two_stop;
            TxD        <= 1'b0;
        end else begin
            if (Enable && (state != ST_IDLE)) begin
                tick <= bit_end ? '0 : tick + TW'(1);
            end
            case (state)
                ST_IDLE: begin
                    TxD <= 1'b1;
                end
                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                        TxD   <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_cnt == BW'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            if (parity_on) begin
                                state <= ST_PARITY;
                                TxD   <= parity_bit;
                            end else begin
                                state <= ST_STOP;
                                TxD   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            TxD     <= shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                        TxD   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_done) begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    TxD   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default 8-bit instance plus a 7-bit,
// 4x-oversampled instance driven by a sparse Enable.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       cs = 1'b0;
    logic       rw = 1'b0;
    logic [1:0] addr = 2'b00;
    logic [7:0] data = 8'h00;
    logic [1:0] pmode = 2'b00;
    logic       tstop = 1'b0;
    logic       txd, tbr, busy, ovf;
    logic [3:0] cnt;

    logic       en7 = 1'b0;
    logic       cs7 = 1'b0;
    logic       rw7 = 1'b0;
    logic [1:0] addr7 = 2'b00;
    logic [6:0] data7 = 7'h00;
    logic [1:0] pmode7 = 2'b00;
    logic       tstop7 = 1'b0;
    logic       txd7, tbr7, busy7, ovf7;
    logic [3:0] cnt7;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo u_dut (
        .clk(clk), .rst(rst), .Enable(en), .IOCS(cs), .IORW(rw), .IOADDR(addr),
        .DATA(data), .parity_mode(pmode), .two_stop(tstop), .TxD(txd), .TBR(tbr),
        .tx_busy(busy), .fifo_count(cnt), .overflow(ovf)
    );

    uart_tx_fifo #(.DATA_W(7), .DEPTH(8), .OVERSAMPLE(4)) u_dut7 (
        .clk(clk), .rst(rst), .Enable(en7), .IOCS(cs7), .IORW(rw7), .IOADDR(addr7),
        .DATA(data7), .parity_mode(pmode7), .two_stop(tstop7), .TxD(txd7), .TBR(tbr7),
        .tx_busy(busy7), .fifo_count(cnt7), .overflow(ovf7)
    );

    initial forever #5 clk = ~clk;

    // Enable for the narrow instance: one cycle in three.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph  = (ph == 2) ? 0 : ph + 1;
            en7 = (ph == 0);
        end
    end

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        cs   = 1'b1;
        rw   = 1'b0;
        addr = a;
        data = d;
        @(negedge clk);
        cs   = 1'b0;
    endtask

    // Entered at the negedge after the start-bit edge; with Enable held high each
    // bit spans 16 cycles. Samples mid-bit and on the last cycle of each bit.
    task automatic expect_frame(input string name, input logic [15:0] bits, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            repeat (8) @(negedge clk);
            n_vec++;
            if (txd !== bits[k]) begin
                n_err++;
                $display("FAIL %s mid bit %0d: got %b expected %b", name, k, txd, bits[k]);
            end
            repeat (7) @(negedge clk);
            n_vec++;
            if (txd !== bits[k] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s end bit %0d: got txd=%b busy=%b expected txd=%b busy=1",
                         name, k, txd, busy, bits[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({txd, tbr, busy, cnt, ovf} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got txd=%b tbr=%b busy=%b cnt=%0d ovf=%b expected 1 1 0 0 0",
                     txd, tbr, busy, cnt, ovf);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame;
        en    = 1'b1;
        pmode = 2'b00;
        tstop = 1'b0;
        bus_write(2'b00, 8'h55);
        n_vec++;
        if ({txd, cnt, busy} !== {1'b1, 4'd1, 1'b1}) begin
            n_err++;
            $display("FAIL single_after_write: got txd=%b cnt=%0d busy=%b expected 1 1 1", txd, cnt, busy);
        end
        @(negedge clk);
        n_vec++;
        if ({txd, cnt} !== {1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL single_latency: got txd=%b cnt=%0d expected 0 0", txd, cnt);
        end
        expect_frame("frame_55", {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        n_vec++;
        if ({txd, busy} !== {1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_done: got txd=%b busy=%b expected 1 0", txd, busy);
        end
    endtask

    task automatic test_parity;
        logic [1:0] modes [2];
        logic       pbits [2];
        modes[0] = 2'b01; pbits[0] = 1'b0;
        modes[1] = 2'b10; pbits[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pmode = modes[i];
            tstop = 1'b1;
            bus_write(2'b00, 8'hA3);
            @(negedge clk);
            // Mid-frame config change must not touch the frame in flight.
            pmode = ~modes[i];
            tstop = 1'b0;
            n_vec++;
            if (txd !== 1'b0) begin
                n_err++;
                $display("FAIL parity_start %0d: got %b expected 0", i, txd);
            end
            expect_frame(i == 0 ? "frame_a3_even" : "frame_a3_odd",
                         {4'b0, 2'b11, pbits[i], 8'hA3, 1'b0}, 12);
            n_vec++;
            if ({txd, busy} !== {1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL parity_done %0d: got txd=%b busy=%b expected 1 0", i, txd, busy);
            end
        end
        pmode = 2'b00;
        tstop = 1'b0;
    endtask

    task automatic test_overflow;
        en = 1'b0;
        for (int i = 0; i < 7; i++) bus_write(2'b00, 8'(i));
        n_vec++;
        if ({tbr, cnt} !== {1'b1, 4'd7}) begin
            n_err++;
            $display("FAIL fill_7: got tbr=%b cnt=%0d expected 1 7", tbr, cnt);
        end
        bus_write(2'b00, 8'h07);
        n_vec++;
        if ({tbr, cnt, ovf, txd, busy} !== {1'b0, 4'd8, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL fill_8: got tbr=%b cnt=%0d ovf=%b txd=%b busy=%b expected 0 8 0 1 1",
                     tbr, cnt, ovf, txd, busy);
        end
        bus_write(2'b00, 8'h08);
        n_vec++;
        if ({cnt, ovf} !== {4'd8, 1'b1}) begin
            n_err++;
            $display("FAIL overflow_set: got cnt=%0d ovf=%b expected 8 1", cnt, ovf);
        end
        cs = 1'b1; rw = 1'b1; addr = 2'b01; data = 8'h01;
        @(negedge clk);
        cs = 1'b0; rw = 1'b0;
        n_vec++;
        if ({cnt, ovf} !== {4'd8, 1'b1}) begin
            n_err++;
            $display("FAIL read_no_effect: got cnt=%0d ovf=%b expected 8 1", cnt, ovf);
        end
        bus_write(2'b01, 8'h00);
        n_vec++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL clear_bit0_zero: got ovf=%b expected 1", ovf);
        end
        bus_write(2'b01, 8'h01);
        n_vec++;
        if ({cnt, ovf} !== {4'd8, 1'b0}) begin
            n_err++;
            $display("FAIL overflow_clear: got cnt=%0d ovf=%b expected 8 0", cnt, ovf);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b;
        // FIFO holds 0..7; the first pop and a push of 0x09 share one edge.
        en = 1'b1;
        bus_write(2'b00, 8'h09);
        n_vec++;
        if ({cnt, tbr, ovf, txd} !== {4'd8, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL push_pop_full: got cnt=%0d tbr=%b ovf=%b txd=%b expected 8 0 0 0",
                     cnt, tbr, ovf, txd);
        end
        for (int k = 0; k < 9; k++) begin
            b = (k < 8) ? 8'(k) : 8'h09;
            expect_frame("b2b_frame", {6'b0, 1'b1, b, 1'b0}, 10);
            n_vec++;
            if (cnt !== ((k < 8) ? 4'(7 - k) : 4'd0)) begin
                n_err++;
                $display("FAIL b2b_count %0d: got %0d expected %0d", k, cnt, (k < 8) ? 7 - k : 0);
            end
        end
        n_vec++;
        if ({txd, busy} !== {1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_done: got txd=%b busy=%b expected 1 0", txd, busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        int bad;
        en = 1'b1;
        bus_write(2'b00, 8'hFF);
        bus_write(2'b00, 8'h12);
        repeat (16 + 16 * 3 + 5) @(negedge clk);
        n_vec++;
        if ({txd, busy, cnt} !== {1'b1, 1'b1, 4'd1}) begin
            n_err++;
            $display("FAIL pre_reset: got txd=%b busy=%b cnt=%0d expected 1 1 1", txd, busy, cnt);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({txd, tbr, busy, cnt, ovf} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got txd=%b tbr=%b busy=%b cnt=%0d ovf=%b expected 1 1 0 0 0",
                     txd, tbr, busy, cnt, ovf);
        end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %0d non-idle cycles expected 0", bad);
        end
    endtask

    task automatic wait_txd7(input logic v, input int limit, output int waited);
        waited = 0;
        while (txd7 !== v && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic test_narrow_frame;
        int w;
        cs7 = 1'b1; addr7 = 2'b00; data7 = 7'h41;
        @(negedge clk);
        cs7 = 1'b0;
        wait_txd7(1'b0, 10, w);
        n_vec++;
        if (txd7 !== 1'b0) begin
            n_err++;
            $display("FAIL narrow_start: got txd=%b after %0d cycles expected 0", txd7, w);
        end
        wait_txd7(1'b1, 30, w);
        n_vec++;
        if (w !== 12) begin
            n_err++;
            $display("FAIL narrow_start_len: got %0d cycles expected 12", w);
        end
        wait_txd7(1'b0, 30, w);
        n_vec++;
        if (w !== 12) begin
            n_err++;
            $display("FAIL narrow_d0_len: got %0d cycles expected 12", w);
        end
        wait_txd7(1'b1, 80, w);
        n_vec++;
        if (w !== 60) begin
            n_err++;
            $display("FAIL narrow_d1_d5_len: got %0d cycles expected 60", w);
        end
        w = 0;
        while (busy7 !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
            if (txd7 !== 1'b1) w = 99;
        end
        n_vec++;
        if (w !== 24) begin
            n_err++;
            $display("FAIL narrow_d6_stop_len: got %0d cycles expected 24", w);
        end
        n_vec++;
        if ({cnt7, tbr7, ovf7} !== {4'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL narrow_final: got cnt=%0d tbr=%b ovf=%b expected 0 1 0", cnt7, tbr7, ovf7);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_narrow_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte SPART transmitter. It accepts characters from the SPART bus interface (DATA/IOADDR/IORW/IOCS) into a DEPTH-entry FIFO and serialises them on TxD, LSB first. Data width, optional parity and stop-bit count are configurable. Bit timing is derived from the shared baud-generator Enable tick, with OVERSAMPLE ticks per bit. It sits between the bus interface and the TxD pin, in place of the single-buffer transmitter.

Parameters:
DATA_W, 8, character width in bits; legal 5..9.
DEPTH, 8, FIFO entries; power of 2, minimum 2.
OVERSAMPLE, 16, Enable ticks per serial bit; minimum 1.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
Enable  input  1  baud tick, one clk cycle wide.
IOCS  input  1  chip select.
IORW  input  1  1 = read, 0 = write.
IOADDR  input  2  00 = transmit data, 01 = control.
DATA  input  DATA_W  write data.
parity_mode  input  2  00 = none, 01 = even, 10 = odd, 11 = none.
two_stop  input  1  1 = two stop bits.
TxD  output  1  serial line, idle high.
TBR  output  1  transmit buffer ready: FIFO not full.
tx_busy  output  1  high when the FIFO is non-empty or a frame is in progress.
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky flag, set when a write hits a full FIFO.

Behaviour:
- Reset (rst=0, async): TxD=1, TBR=1, tx_busy=0, fifo_count=0, overflow=0. FIFO pointers cleared, FSM to IDLE, tick and bit counters 0. A reset mid-frame aborts the frame and TxD returns high immediately.
- Push: at a clk edge where IOCS=1, IORW=0, IOADDR=00. If not full, DATA is written and the count increments. If full, the write is dropped and overflow is set.
- Clear overflow: IOCS=1, IORW=0, IOADDR=01 with DATA[0]=1. A clear and a set in the same cycle: set wins.
- Read accesses and IOCS=0 have no effect. Transmission continues regardless of IOCS.
- Pointers wrap modulo DEPTH. Full/empty are derived from fifo_count.
- Push and pop in the same cycle: count unchanged. When full, this push is accepted because the pop frees an entry.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, latch parity_mode and two_stop, clear counters, go to START. TxD=0 from that edge.
  - Each bit lasts exactly OVERSAMPLE Enable pulses. The tick counter increments only on Enable=1, and the bit ends on the edge where tick == OVERSAMPLE-1 with Enable=1.
  - START -> DATA.
  - DATA: TxD = shift register bit 0. Shift right at each bit end. After DATA_W bits, go to PARITY if parity is on, else STOP.
  - PARITY: TxD = XOR of the data bits for even parity, inverted for odd.
  - STOP: TxD=1 for 1 or 2 bit times, then back to IDLE.
- Back-to-back frames: if the FIFO is non-empty at STOP end, the next START begins on the following edge, with no extra idle bit.
- Latency: a write at edge N into an empty, idle block gives TxD=0 after edge N+1.
- Config inputs changed mid-frame do not affect the current frame.
- TBR, fifo_count and tx_busy are registered or derived from registered state only; no combinational path from bus inputs.
- Frame length in bits = 1 + DATA_W + (parity on) + (1 + two_stop).

Test Plan:
- Reset, Enable held 1, write 0x55, no parity, 1 stop -> TxD low after the next edge. Bits are 0,1,0,1,0,1,0,1,0,1, each 16 cycles, 160 cycles total. tx_busy then falls.
- Write 0xA3 with parity_mode=01, two_stop=1 -> bits 0, 1,1,0,0,0,1,0,1, parity 0, then 1,1. Repeat with parity_mode=10 -> parity bit 1.
- Nine writes (0x00..0x08) back-to-back with Enable=0 -> TBR=0 after the 8th write, fifo_count=8, 9th write dropped, overflow=1. Write IOADDR=01 with DATA=1 -> overflow=0.
- Full FIFO with a pop and a push on the same edge -> push accepted, fifo_count stays 8. Frames appear in write order with no idle gap between stop and start.
- Assert rst mid-DATA of 0xFF -> TxD=1 asynchronously, fifo_count=0. After release, the line stays idle.
- DATA_W=7, OVERSAMPLE=4, Enable every 3rd cycle, write 0x41 -> 9-bit frame, each bit 12 cycles.
